// File: rtl/pcie_rs_pkg.sv
// Shared types and constants for the PCIe hard-IP reset sequencer.
package pcie_rs_pkg;

  typedef enum logic [2:0] {
    StWaitPll,
    StCoreHold,
    StLinkWait,
    StAppHold,
    StRun,
    StFatal
  } state_e;

  localparam logic [4:0] LTSSM_L0 = 5'h0F;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_DLUP    = 3'd1;
  localparam logic [2:0] CAUSE_HOTRST  = 3'd2;
  localparam logic [2:0] CAUSE_L2      = 3'd3;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd4;

  // Last timer value of a dwell of N cycles; test_sim shortens every dwell.
  function automatic int unsigned dwell_last(input logic sim, input int unsigned cyc,
                                             input int unsigned sim_cyc);
    return sim ? sim_cyc - 1 : cyc - 1;
  endfunction

endpackage

// File: rtl/pcie_rs_sync.sv
// Two-flop synchroniser with asynchronous clear.
module pcie_rs_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pcie_rs_hip_seq.sv
// Reset sequencer for PCIe hard IP: orders core/app reset release behind PLL lock,
// reconfig idle and link L0, retrains on link exits and escalates to fatal.
module pcie_rs_hip_seq
  import pcie_rs_pkg::*;
#(
  parameter int unsigned LANES          = 4,
  parameter int unsigned CNT_W          = 20,
  parameter int unsigned PLL_STABLE_CYC = 1024,
  parameter int unsigned CORE_HOLD_CYC  = 32,
  parameter int unsigned APP_HOLD_CYC   = 64,
  parameter int unsigned LTSSM_TO_CYC   = 500000,
  parameter int unsigned SIM_CYC        = 16,
  parameter int unsigned MAX_RETRAIN    = 3
) (
  input  logic       pld_clk,
  input  logic       npor,
  input  logic       pll_locked,
  input  logic       busy_reconfig,
  input  logic       test_sim,
  input  logic [4:0] ltssm,
  input  logic [3:0] lane_act,
  input  logic       dlup_exit,
  input  logic       hotrst_exit,
  input  logic       l2_exit,
  output logic       crst,
  output logic       srst,
  output logic       app_rstn,
  output logic       link_up,
  output logic       degraded,
  output logic       fatal,
  output logic [2:0] rst_cause,
  output logic [3:0] retrain_cnt
);

  logic pll_s, busy_s;

  pcie_rs_sync u_sync_pll (
    .clk_i  (pld_clk),
    .rst_ni (npor),
    .d_i    (pll_locked),
    .q_o    (pll_s)
  );

  pcie_rs_sync u_sync_busy (
    .clk_i  (pld_clk),
    .rst_ni (npor),
    .d_i    (busy_reconfig),
    .q_o    (busy_s)
  );

  logic [CNT_W-1:0] pll_lim, core_lim, app_lim, to_lim;

  assign pll_lim  = CNT_W'(dwell_last(test_sim, PLL_STABLE_CYC, SIM_CYC));
  assign core_lim = CNT_W'(dwell_last(test_sim, CORE_HOLD_CYC, SIM_CYC));
  assign app_lim  = CNT_W'(dwell_last(test_sim, APP_HOLD_CYC, SIM_CYC));
  assign to_lim   = CNT_W'(dwell_last(test_sim, LTSSM_TO_CYC, SIM_CYC));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       retry_q, retry_d;
  logic [3:0]       retrain_cnt_q, retrain_cnt_d;
  logic [2:0]       rst_cause_q, rst_cause_d;
  logic             degraded_q, degraded_d;
  logic             crst_q, crst_d;
  logic             app_rstn_q, app_rstn_d;
  logic             link_up_q, link_up_d;
  logic             fatal_q, fatal_d;
  logic             retrain;
  logic [2:0]       retrain_cause;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q + CNT_W'(1);
    retry_d       = retry_q;
    retrain_cnt_d = retrain_cnt_q;
    rst_cause_d   = rst_cause_q;
    degraded_d    = degraded_q | ((state_q == StRun) && (32'(lane_act) < LANES));
    retrain       = 1'b0;
    retrain_cause = CAUSE_NONE;

    // Loss of PLL lock outranks every retrain cause and is not counted.
    unique case (state_q)
      StWaitPll: begin
        if (pll_s && !busy_s) begin
          if (timer_q == pll_lim) state_d = StCoreHold;
        end else begin
          timer_d = '0;
        end
      end
      StCoreHold: begin
        if (!pll_s) state_d = StWaitPll;
        else if (timer_q == core_lim) state_d = StLinkWait;
      end
      StLinkWait: begin
        if (!pll_s) begin
          state_d = StWaitPll;
        end else if (ltssm == LTSSM_L0) begin
          state_d = StAppHold;
        end else if (timer_q == to_lim) begin
          retrain       = 1'b1;
          retrain_cause = CAUSE_TIMEOUT;
        end
      end
      StAppHold: begin
        if (!pll_s) begin
          state_d = StWaitPll;
        end else if (!hotrst_exit) begin
          retrain       = 1'b1;
          retrain_cause = CAUSE_HOTRST;
        end else if (ltssm != LTSSM_L0) begin
          state_d = StLinkWait;
        end else if (timer_q == app_lim) begin
          state_d = StRun;
          retry_d = '0;
        end
      end
      StRun: begin
        if (!pll_s) begin
          state_d = StWaitPll;
        end else if (!dlup_exit) begin
          retrain       = 1'b1;
          retrain_cause = CAUSE_DLUP;
        end else if (!hotrst_exit) begin
          retrain       = 1'b1;
          retrain_cause = CAUSE_HOTRST;
        end else if (!l2_exit) begin
          retrain       = 1'b1;
          retrain_cause = CAUSE_L2;
        end
      end
      StFatal: begin
        timer_d = timer_q;
      end
      default: state_d = StWaitPll;
    endcase

    if (retrain) begin
      retrain_cnt_d = (retrain_cnt_q == 4'hF) ? retrain_cnt_q : retrain_cnt_q + 4'd1;
      rst_cause_d   = retrain_cause;
      retry_d       = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
      state_d       = (32'(retry_d) > MAX_RETRAIN) ? StFatal : StCoreHold;
    end

    if (state_d != state_q) timer_d = '0;

    // Pins follow the next state so they change on the same edge as the state register.
    crst_d     = (state_d == StWaitPll) || (state_d == StCoreHold);
    app_rstn_d = (state_d == StRun);
    link_up_d  = (state_d == StRun);
    fatal_d    = (state_d == StFatal);
  end

  always_ff @(posedge pld_clk or negedge npor) begin
    if (!npor) begin
      state_q       <= StWaitPll;
      timer_q       <= '0;
      retry_q       <= '0;
      retrain_cnt_q <= '0;
      rst_cause_q   <= CAUSE_NONE;
      degraded_q    <= 1'b0;
      crst_q        <= 1'b1;
      app_rstn_q    <= 1'b0;
      link_up_q     <= 1'b0;
      fatal_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      retrain_cnt_q <= retrain_cnt_d;
      rst_cause_q   <= rst_cause_d;
      degraded_q    <= degraded_d;
      crst_q        <= crst_d;
      app_rstn_q    <= app_rstn_d;
      link_up_q     <= link_up_d;
      fatal_q       <= fatal_d;
    end
  end

  assign crst        = crst_q;
  assign srst        = crst_q;
  assign app_rstn    = app_rstn_q;
  assign link_up     = link_up_q;
  assign degraded    = degraded_q;
  assign fatal       = fatal_q;
  assign rst_cause   = rst_cause_q;
  assign retrain_cnt = retrain_cnt_q;

endmodule
